truth_table_sweeper: RTL and testbench

//  Upstream stimulus/capture stage for the simple2 combinational circuit (inputs A,B,C -> D).
//  On start, it drives every input combination from 0 to 2^N-1 in ascending order.

---
 rtl/truth_table_sweeper_pkg.sv | 14 +
 rtl/sweep_hold_counter.sv | 32 +++
 rtl/truth_table_sweeper.sv | 100 ++++++++++
 tb/tb_truth_table_sweeper.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and defaults for the truth-table sweeper.
// State encoding and parameter defaults used by the top and its hold counter.
package truth_table_sweeper_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEF_NUM_INPUTS  = 3;
   localparam int DEF_HOLD_CYCLES = 20;
   localparam int DEF_HOLD_W      = 16;

endpackage

// File: rtl/sweep_hold_counter.sv
// Per-vector hold timer for the truth-table sweeper.
// Flags the last cycle of each hold window and wraps to zero on it.
module sweep_hold_counter
   import truth_table_sweeper_pkg::*;
#(
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int HOLD_W      = DEF_HOLD_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic terminal
);

   localparam logic [HOLD_W-1:0] LP_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic [HOLD_W-1:0] r_count;
   logic              w_term;

   assign w_term   = (r_count == LP_LAST);
   assign terminal = w_term;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= w_term ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Self-timed stimulus/capture stage: sweeps every input vector of a
// combinational circuit and records its output as a truth table.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int HOLD_W      = DEF_HOLD_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     dut_out,
   output logic [NUM_INPUTS-1:0]    vec_out,
   output logic [2**NUM_INPUTS-1:0] table_out,
   output logic                     busy,
   output logic                     done,
   output logic                     valid
);

   localparam int                    LP_NV   = 2**NUM_INPUTS;
   localparam logic [NUM_INPUTS-1:0] LP_VMAX = '1;

   state_t                  r_state;
   logic [NUM_INPUTS-1:0]   r_vec;
   logic [LP_NV-1:0]        r_table;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_valid;
   logic                    w_term;
   logic                    w_clr;
   logic                    w_en;

   // Counter is held at zero outside RUN so every sweep starts a fresh window.
   assign w_clr = (r_state == ST_IDLE) || abort;
   assign w_en  = (r_state == ST_RUN);

   sweep_hold_counter #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .HOLD_W      (HOLD_W)
   ) u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (w_clr),
      .en       (w_en),
      .terminal (w_term)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_vec   <= '0;
         r_table <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (start && !abort) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
                  r_vec   <= '0;
                  r_valid <= 1'b0;
                  r_table <= '0;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_vec   <= '0;
                  r_valid <= 1'b0;
               end else if (w_term) begin
                  r_table[r_vec] <= dut_out;
                  if (r_vec == LP_VMAX) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_valid <= 1'b1;
                     r_vec   <= '0;
                  end else begin
                     r_vec <= r_vec + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign vec_out   = r_vec;
   assign table_out = r_table;
   assign busy      = r_busy;
   assign done      = r_done;
   assign valid     = r_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: parity stub on a HOLD=20 sweeper, AND stub on a HOLD=1 sweeper.
// Expected tables and timing are hand-computed constants.
module tb_truth_table_sweeper;

   logic       clk;
   logic       rst_n;
   logic       s20, a20, d20, busy20, done20, val20;
   logic [2:0] vec20;
   logic [7:0] tab20;
   logic       s1, a1, d1, busy1, done1, val1;
   logic [2:0] vec1;
   logic [7:0] tab1;

   int n_vec = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign d20 = ^vec20;
   assign d1  = vec1[2] & vec1[1];

   truth_table_sweeper #(
      .NUM_INPUTS (3),
      .HOLD_CYCLES(20),
      .HOLD_W     (16)
   ) u_dut20 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (s20),
      .abort    (a20),
      .dut_out  (d20),
      .vec_out  (vec20),
      .table_out(tab20),
      .busy     (busy20),
      .done     (done20),
      .valid    (val20)
   );

   truth_table_sweeper #(
      .NUM_INPUTS (3),
      .HOLD_CYCLES(1),
      .HOLD_W     (16)
   ) u_dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (s1),
      .abort    (a1),
      .dut_out  (d1),
      .vec_out  (vec1),
      .table_out(tab1),
      .busy     (busy1),
      .done     (done1),
      .valid    (val1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      s20 = 1'b1; a20 = 1'b0;
      s1  = 1'b1; a1  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if ({busy20, done20, val20, vec20, tab20} !== 14'h0) begin
            n_err++;
            $display("FAIL reset20: got %h want 0",
                     {busy20, done20, val20, vec20, tab20});
         end
         n_vec++;
         if ({busy1, done1, val1, vec1, tab1} !== 14'h0) begin
            n_err++;
            $display("FAIL reset1: got %h want 0",
                     {busy1, done1, val1, vec1, tab1});
         end
      end
      s20 = 1'b0; s1 = 1'b0;
      rst_n = 1'b1;
      tick();
      n_vec++;
      if ({busy20, busy1, done20, done1} !== 4'h0) begin
         n_err++;
         $display("FAIL post_reset_idle: got %h want 0",
                  {busy20, busy1, done20, done1});
      end
   endtask

   // Full parity sweep; start is accepted on the first edge (edge k).
   task automatic test_parity();
      s20 = 1'b1;
      tick();
      s20 = 1'b0;
      n_vec++;
      if ({busy20, done20, val20, vec20, tab20} !== {3'b100, 3'd0, 8'h00}) begin
         n_err++;
         $display("FAIL par_start: got %h want %h",
                  {busy20, done20, val20, vec20, tab20},
                  {3'b100, 3'd0, 8'h00});
      end
      for (int n = 1; n <= 160; n++) begin
         tick();
         n_vec++;
         if (n < 160) begin
            if ({busy20, done20, vec20} !== {2'b10, 3'(n / 20)}) begin
               n_err++;
               $display("FAIL par_step n=%0d: got %h want %h", n,
                        {busy20, done20, vec20}, {2'b10, 3'(n / 20)});
            end
         end else begin
            if ({busy20, done20, val20, vec20, tab20} !==
                {3'b011, 3'd0, 8'h96}) begin
               n_err++;
               $display("FAIL par_done: got %h want %h",
                        {busy20, done20, val20, vec20, tab20},
                        {3'b011, 3'd0, 8'h96});
            end
         end
      end
      tick();
      n_vec++;
      if ({busy20, done20, val20, tab20} !== {3'b001, 8'h96}) begin
         n_err++;
         $display("FAIL par_after: got %h want %h",
                  {busy20, done20, val20, tab20}, {3'b001, 8'h96});
      end
   endtask

   task automatic test_back_to_back();
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         n_vec++;
         if (n < 8) begin
            if ({busy1, done1, vec1} !== {2'b10, 3'(n)}) begin
               n_err++;
               $display("FAIL and_step n=%0d: got %h want %h", n,
                        {busy1, done1, vec1}, {2'b10, 3'(n)});
            end
         end else if ({busy1, done1, val1, vec1, tab1} !==
                      {3'b011, 3'd0, 8'hC0}) begin
            n_err++;
            $display("FAIL and_done: got %h want %h",
                     {busy1, done1, val1, vec1, tab1},
                     {3'b011, 3'd0, 8'hC0});
         end
      end
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      n_vec++;
      if ({busy1, done1, val1, vec1, tab1} !== {3'b100, 3'd0, 8'h00}) begin
         n_err++;
         $display("FAIL b2b_start: got %h want %h",
                  {busy1, done1, val1, vec1, tab1}, {3'b100, 3'd0, 8'h00});
      end
      for (int n = 1; n <= 8; n++) begin
         tick();
         n_vec++;
         if (n < 8) begin
            if ({busy1, done1, val1, vec1} !== {3'b100, 3'(n)}) begin
               n_err++;
               $display("FAIL b2b_step n=%0d: got %h want %h", n,
                        {busy1, done1, val1, vec1}, {3'b100, 3'(n)});
            end
         end else if ({busy1, done1, val1, tab1} !== {3'b011, 8'hC0}) begin
            n_err++;
            $display("FAIL b2b_done: got %h want %h",
                     {busy1, done1, val1, tab1}, {3'b011, 8'hC0});
         end
      end
   endtask

   task automatic test_abort();
      s20 = 1'b1;
      tick();
      s20 = 1'b0;
      for (int n = 1; n <= 64; n++) tick();
      a20 = 1'b1;
      tick();
      a20 = 1'b0;
      n_vec++;
      if ({busy20, done20, val20, vec20, tab20} !== {3'b000, 3'd0, 8'h06}) begin
         n_err++;
         $display("FAIL abort: got %h want %h",
                  {busy20, done20, val20, vec20, tab20},
                  {3'b000, 3'd0, 8'h06});
      end
      for (int n = 0; n < 30; n++) begin
         tick();
         n_vec++;
         if ({busy20, done20, val20, tab20} !== {3'b000, 8'h06}) begin
            n_err++;
            $display("FAIL abort_quiet n=%0d: got %h want %h", n,
                     {busy20, done20, val20, tab20}, {3'b000, 8'h06});
         end
      end
   endtask

   task automatic test_start_held();
      int dones;
      dones = 0;
      s20 = 1'b1;
      tick();
      for (int n = 1; n <= 330; n++) begin
         tick();
         if (done20) dones++;
         n_vec++;
         if (done20 && busy20) begin
            n_err++;
            $display("FAIL held_overlap n=%0d: got busy=1 done=1 want busy=0",
                     n);
         end
      end
      n_vec++;
      if (dones !== 2) begin
         n_err++;
         $display("FAIL held_dones: got %0d want 2", dones);
      end
      s20 = 1'b0;
      a20 = 1'b1;
      tick();
      n_vec++;
      if ({busy20, done20, val20, vec20, tab20} !== 14'h0) begin
         n_err++;
         $display("FAIL held_abort: got %h want 0",
                  {busy20, done20, val20, vec20, tab20});
      end
      s20 = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         n_vec++;
         if ({busy20, done20, vec20} !== 5'h0) begin
            n_err++;
            $display("FAIL start_abort_idle n=%0d: got %h want 0", n,
                     {busy20, done20, vec20});
         end
      end
      s20 = 1'b0;
      a20 = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      s20 = 1'b1;
      tick();
      s20 = 1'b0;
      for (int n = 1; n <= 99; n++) tick();
      rst_n = 1'b0;
      tick();
      n_vec++;
      if ({busy20, done20, val20, vec20, tab20} !== 14'h0) begin
         n_err++;
         $display("FAIL mid_reset: got %h want 0",
                  {busy20, done20, val20, vec20, tab20});
      end
      rst_n = 1'b1;
      for (int n = 0; n < 25; n++) begin
         tick();
         n_vec++;
         if ({busy20, done20, val20, vec20, tab20} !== 14'h0) begin
            n_err++;
            $display("FAIL mid_reset_quiet n=%0d: got %h want 0", n,
                     {busy20, done20, val20, vec20, tab20});
         end
      end
      test_parity();
   endtask

   initial begin
      rst_n = 1'b0;
      s20 = 1'b0; a20 = 1'b0;
      s1  = 1'b0; a1  = 1'b0;
      test_reset();
      test_parity();
      test_back_to_back();
      test_abort();
      test_start_held();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
